in_pkt_fifo: RTL and testbench

IN_PKT_FIFO -- requirements
Module: in_pkt_fifo

---
 rtl/usb_fifo_pkg.sv | 13 +
 rtl/in_pkt_fifo_if.sv | 37 +++
 rtl/fifo_ram.sv | 23 ++
 rtl/in_pkt_fifo.sv | 121 ++++++++++++
 tb/tb_in_pkt_fifo.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_fifo_pkg.sv
// usb_fifo_pkg: shared definitions for the IN packet FIFO.
//   fifo_state_e : packet-engine FSM encoding (idle / sending a packet)
//   MAX_PKT_DEF  : default maximum IN packet size in bytes
package usb_fifo_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } fifo_state_e;

  localparam int MAX_PKT_DEF = 8;

endpackage

// File: rtl/in_pkt_fifo_if.sv
// in_pkt_fifo_if: application write side plus protocol-engine IN side.
//   app_in_*      : byte stream in, valid/ready handshake, last marks message end
//   in_req_i      : host IN token pulse, starts a packet
//   in_ready_i    : engine consumes in_data_o this cycle
//   in_data_ack_i : host ACKed the packet (commit)
//   in_abort_i    : packet failed (rewind)
//   in_data_o/in_valid_o, pkt_avail_o, level_o : FIFO outputs
// slave = FIFO side, master = application / protocol engine side.
interface in_pkt_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64
);
  logic [DATA_W-1:0]      app_in_data_i;
  logic                   app_in_last_i;
  logic                   app_in_valid_i;
  logic                   app_in_ready_o;
  logic                   in_req_i;
  logic                   in_ready_i;
  logic                   in_data_ack_i;
  logic                   in_abort_i;
  logic [DATA_W-1:0]      in_data_o;
  logic                   in_valid_o;
  logic                   pkt_avail_o;
  logic [$clog2(DEPTH):0] level_o;

  modport slave (
    input  app_in_data_i, app_in_last_i, app_in_valid_i,
    input  in_req_i, in_ready_i, in_data_ack_i, in_abort_i,
    output app_in_ready_o, in_data_o, in_valid_o, pkt_avail_o, level_o
  );

  modport master (
    output app_in_data_i, app_in_last_i, app_in_valid_i,
    output in_req_i, in_ready_i, in_data_ack_i, in_abort_i,
    input  app_in_ready_o, in_data_o, in_valid_o, pkt_avail_o, level_o
  );
endinterface

// File: rtl/fifo_ram.sv
// fifo_ram: register-array storage, synchronous write, asynchronous read.
//   clk_i           : write clock
//   we_i/waddr_i/wdata_i : write port
//   raddr_i/rdata_o : combinational read port
module fifo_ram #(
  parameter int W     = 9,
  parameter int DEPTH = 64
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/in_pkt_fifo.sv
// in_pkt_fifo: IN-endpoint FIFO with packet retry and zero-length packets.
// Bytes are read speculatively through sp_ptr while a packet is sent; the
// host ACK commits them (rd_ptr <= sp_ptr), an abort rewinds (sp_ptr <= rd_ptr).
// A message whose final packet is exactly MAX_PKT bytes is followed by a ZLP.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : in_pkt_fifo_if.slave (app write side + protocol-engine side)
module in_pkt_fifo
  import usb_fifo_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 64,
  parameter int MAX_PKT = MAX_PKT_DEF,
  parameter int ZLP_EN  = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  in_pkt_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_PKT + 1);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PKT);

  fifo_state_e       state_q, state_d;
  logic [PW-1:0]     wr_ptr, rd_ptr, sp_ptr, level;
  logic [CW-1:0]     pkt_cnt;
  logic              last_seen, zlp_pend;
  logic              wr_en, in_valid;
  logic [DATA_W:0]   rd_word;
  logic              do_start, do_rewind, do_commit, do_adv;

  // Unacked bytes stay counted against capacity until commit.
  assign level              = wr_ptr - rd_ptr;
  assign bus.level_o        = level;
  assign bus.app_in_ready_o = level < DEPTH_P;
  assign bus.pkt_avail_o    = (wr_ptr != rd_ptr) || zlp_pend;
  assign wr_en              = bus.app_in_valid_i && bus.app_in_ready_o;

  fifo_ram #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wr_ptr[AW-1:0]),
    .wdata_i ({bus.app_in_last_i, bus.app_in_data_i}),
    .raddr_i (sp_ptr[AW-1:0]),
    .rdata_o (rd_word)
  );

  // Gate data so it reads 0 whenever nothing valid is presented.
  assign bus.in_valid_o = in_valid;
  assign bus.in_data_o  = in_valid ? rd_word[DATA_W-1:0] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Priority in SEND: new token (implicit rewind) > abort > ack > consume.
  always_comb begin
    state_d   = state_q;
    in_valid  = 1'b0;
    do_start  = 1'b0;
    do_rewind = 1'b0;
    do_commit = 1'b0;
    do_adv    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_req_i) begin
          state_d  = ST_SEND;
          do_start = 1'b1;
        end
      end
      ST_SEND: begin
        in_valid = (sp_ptr != wr_ptr) && (pkt_cnt < MAX_CNT) && !last_seen && !zlp_pend;
        if (bus.in_req_i) begin
          do_start  = 1'b1;
          do_rewind = 1'b1;
        end else if (bus.in_abort_i) begin
          do_rewind = 1'b1;
          state_d   = ST_IDLE;
        end else if (bus.in_data_ack_i) begin
          do_commit = 1'b1;
          state_d   = ST_IDLE;
        end else if (in_valid && bus.in_ready_i) begin
          do_adv = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      sp_ptr    <= '0;
      pkt_cnt   <= '0;
      last_seen <= 1'b0;
      zlp_pend  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (do_start) begin
        pkt_cnt   <= '0;
        last_seen <= 1'b0;
      end
      if (do_rewind) sp_ptr <= rd_ptr;
      if (do_commit) begin
        rd_ptr <= sp_ptr;
        // A pending ZLP makes the acked packet the ZLP itself, so clear it.
        zlp_pend <= zlp_pend ? 1'b0
                             : ((ZLP_EN != 0) && last_seen && (pkt_cnt == MAX_CNT));
      end
      if (do_adv) begin
        sp_ptr    <= sp_ptr + 1'b1;
        pkt_cnt   <= pkt_cnt + 1'b1;
        last_seen <= rd_word[DATA_W];
      end
    end
  end
endmodule

// File: tb/tb_in_pkt_fifo.sv
// tb_in_pkt_fifo: directed scenarios plus randomized traffic against a
// queue-based reference model of the IN packet FIFO.
module tb_in_pkt_fifo;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int MP = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  in_pkt_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  in_pkt_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .MAX_PKT(MP), .ZLP_EN(1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: q holds every stored-but-uncommitted entry {last,data} in order;
  // sp_off is how many of them the current packet has already sent.
  logic [8:0] q[$];
  int sp_off = 0;
  int pcnt = 0;
  bit lseen = 0;
  bit zlp = 0;
  bit send = 0;

  function automatic bit m_valid();
    return send && (sp_off < q.size()) && (pcnt < MP) && !lseen && !zlp;
  endfunction

  task automatic clr_in();
    bus.app_in_valid_i = 1'b0;
    bus.app_in_data_i  = '0;
    bus.app_in_last_i  = 1'b0;
    bus.in_req_i       = 1'b0;
    bus.in_ready_i     = 1'b0;
    bus.in_data_ack_i  = 1'b0;
    bus.in_abort_i     = 1'b0;
  endtask

  // Advance model and DUT by one clock using the inputs currently driven.
  task automatic tick();
    bit wr;
    bit v;
    logic [8:0] w;
    wr = bus.app_in_valid_i && (q.size() < DEPTH);
    w  = {bus.app_in_last_i, bus.app_in_data_i};
    v  = m_valid();
    if (rst) begin
      q.delete();
      sp_off = 0; pcnt = 0; lseen = 0; zlp = 0; send = 0;
    end else begin
      if (send) begin
        if (bus.in_req_i) begin
          sp_off = 0; pcnt = 0; lseen = 0;
        end else if (bus.in_abort_i) begin
          sp_off = 0; send = 0;
        end else if (bus.in_data_ack_i) begin
          zlp = zlp ? 1'b0 : (lseen && pcnt == MP);
          for (int i = 0; i < sp_off; i++) void'(q.pop_front());
          sp_off = 0; send = 0;
        end else if (v && bus.in_ready_i) begin
          lseen = q[sp_off][8];
          sp_off++;
          pcnt++;
        end
      end else if (bus.in_req_i) begin
        send = 1; pcnt = 0; lseen = 0;
      end
      if (wr) q.push_back(w);
    end
    @(posedge clk);
    #1;
    clr_in();
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic l);
    bus.app_in_valid_i = 1'b1;
    bus.app_in_data_i  = d;
    bus.app_in_last_i  = l;
    tick();
  endtask

  task automatic pull(output logic [7:0] d, output logic v);
    v = bus.in_valid_o;
    d = bus.in_data_o;
    bus.in_ready_i = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_rst();
    n_vec++; if (bus.in_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.in_valid_o); end
    n_vec++; if (bus.level_o !== 5'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", bus.level_o); end
    n_vec++; if (bus.pkt_avail_o !== 1'b0) begin n_err++; $display("FAIL rst_avail: got %b want 0", bus.pkt_avail_o); end
    n_vec++; if (bus.app_in_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", bus.app_in_ready_o); end
    n_vec++; if (bus.in_data_o !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", bus.in_data_o); end
  endtask

  task automatic test_zlp();
    logic [7:0] pat [8];
    logic [7:0] d;
    logic v;
    pat = '{8'h87, 8'h65, 8'h43, 8'h21, 8'h87, 8'h65, 8'h43, 8'h21};
    do_rst();
    for (int i = 0; i < 8; i++) wr_byte(pat[i], i == 7);
    n_vec++; if (bus.level_o !== 5'd8 || bus.pkt_avail_o !== 1'b1) begin n_err++; $display("FAIL zlp_fill: got level=%0d avail=%b want 8/1", bus.level_o, bus.pkt_avail_o); end
    bus.in_req_i = 1'b1; tick();
    for (int i = 0; i < 8; i++) begin
      pull(d, v);
      n_vec++; if (v !== 1'b1 || d !== pat[i]) begin n_err++; $display("FAIL zlp_byte%0d: got v=%b d=%h want v=1 d=%h", i, v, d, pat[i]); end
    end
    n_vec++; if (bus.in_valid_o !== 1'b0) begin n_err++; $display("FAIL zlp_end_valid: got %b want 0", bus.in_valid_o); end
    bus.in_data_ack_i = 1'b1; tick();
    n_vec++; if (bus.level_o !== 5'd0 || bus.pkt_avail_o !== 1'b1) begin n_err++; $display("FAIL zlp_pend: got level=%0d avail=%b want 0/1", bus.level_o, bus.pkt_avail_o); end
    bus.in_req_i = 1'b1; tick();
    bus.in_ready_i = 1'b1; tick();
    n_vec++; if (bus.in_valid_o !== 1'b0) begin n_err++; $display("FAIL zlp_empty_pkt: got valid=%b want 0", bus.in_valid_o); end
    bus.in_data_ack_i = 1'b1; tick();
    n_vec++; if (bus.pkt_avail_o !== 1'b0 || bus.level_o !== 5'd0) begin n_err++; $display("FAIL zlp_done: got avail=%b level=%0d want 0/0", bus.pkt_avail_o, bus.level_o); end
  endtask

  task automatic test_abort();
    logic [7:0] d;
    logic v;
    do_rst();
    for (int i = 1; i <= 5; i++) wr_byte(8'(i), i == 5);
    bus.in_req_i = 1'b1; tick();
    for (int i = 1; i <= 3; i++) begin
      pull(d, v);
      n_vec++; if (v !== 1'b1 || d !== 8'(i)) begin n_err++; $display("FAIL abort_pre%0d: got v=%b d=%h want v=1 d=%h", i, v, d, 8'(i)); end
    end
    bus.in_abort_i = 1'b1; tick();
    n_vec++; if (bus.level_o !== 5'd5 || bus.in_valid_o !== 1'b0) begin n_err++; $display("FAIL abort_level: got level=%0d valid=%b want 5/0", bus.level_o, bus.in_valid_o); end
    bus.in_req_i = 1'b1; tick();
    for (int i = 1; i <= 5; i++) begin
      pull(d, v);
      n_vec++; if (v !== 1'b1 || d !== 8'(i)) begin n_err++; $display("FAIL abort_retry%0d: got v=%b d=%h want v=1 d=%h", i, v, d, 8'(i)); end
    end
    n_vec++; if (bus.in_valid_o !== 1'b0) begin n_err++; $display("FAIL abort_after_last: got valid=%b want 0", bus.in_valid_o); end
    bus.in_data_ack_i = 1'b1; tick();
    n_vec++; if (bus.level_o !== 5'd0 || bus.pkt_avail_o !== 1'b0) begin n_err++; $display("FAIL abort_commit: got level=%0d avail=%b want 0/0", bus.level_o, bus.pkt_avail_o); end
  endtask

  task automatic test_full();
    logic [7:0] b [17];
    logic [7:0] d;
    logic v;
    int acc;
    do_rst();
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      b[i] = 8'($urandom);
      if (bus.app_in_ready_o === 1'b1) acc++;
      wr_byte(b[i], 1'b0);
    end
    n_vec++; if (acc != 16) begin n_err++; $display("FAIL full_accepted: got %0d want 16", acc); end
    n_vec++; if (bus.app_in_ready_o !== 1'b0 || bus.level_o !== 5'd16) begin n_err++; $display("FAIL full_state: got ready=%b level=%0d want 0/16", bus.app_in_ready_o, bus.level_o); end
    bus.in_req_i = 1'b1; tick();
    for (int i = 0; i < 8; i++) begin
      pull(d, v);
      n_vec++; if (v !== 1'b1 || d !== b[i]) begin n_err++; $display("FAIL full_byte%0d: got v=%b d=%h want v=1 d=%h", i, v, d, b[i]); end
    end
    n_vec++; if (bus.in_valid_o !== 1'b0 || bus.app_in_ready_o !== 1'b0) begin n_err++; $display("FAIL full_maxpkt: got valid=%b ready=%b want 0/0", bus.in_valid_o, bus.app_in_ready_o); end
    bus.in_data_ack_i = 1'b1; tick();
    n_vec++; if (bus.app_in_ready_o !== 1'b1 || bus.level_o !== 5'd8) begin n_err++; $display("FAIL full_commit: got ready=%b level=%0d want 1/8", bus.app_in_ready_o, bus.level_o); end
  endtask

  task automatic test_ack_abort();
    logic [7:0] d;
    logic v;
    do_rst();
    for (int i = 0; i < 10; i++) wr_byte(8'hA0 + 8'(i), 1'b0);
    bus.in_req_i = 1'b1; tick();
    for (int i = 0; i < 4; i++) pull(d, v);
    bus.in_data_ack_i = 1'b1; bus.in_abort_i = 1'b1; tick();
    n_vec++; if (bus.level_o !== 5'd10 || bus.in_valid_o !== 1'b0) begin n_err++; $display("FAIL ackabort_level: got level=%0d valid=%b want 10/0", bus.level_o, bus.in_valid_o); end
    bus.in_req_i = 1'b1; tick();
    for (int i = 0; i < 2; i++) begin
      pull(d, v);
      n_vec++; if (v !== 1'b1 || d !== 8'hA0 + 8'(i)) begin n_err++; $display("FAIL ackabort_byte%0d: got v=%b d=%h want v=1 d=%h", i, v, d, 8'hA0 + 8'(i)); end
    end
    bus.in_req_i = 1'b1; bus.in_ready_i = 1'b1; tick();
    n_vec++; if (bus.in_valid_o !== 1'b1 || bus.in_data_o !== 8'hA0) begin n_err++; $display("FAIL rereq_restart: got v=%b d=%h want v=1 d=a0", bus.in_valid_o, bus.in_data_o); end
    pull(d, v);
    n_vec++; if (bus.in_data_o !== 8'hA1 || bus.level_o !== 5'd10) begin n_err++; $display("FAIL rereq_next: got d=%h level=%0d want a1/10", bus.in_data_o, bus.level_o); end
    bus.in_abort_i = 1'b1; tick();
  endtask

  task automatic test_reset_inflight();
    logic [7:0] d;
    logic v;
    do_rst();
    for (int i = 0; i < 6; i++) wr_byte(8'h30 + 8'(i), i == 5);
    bus.in_req_i = 1'b1; tick();
    for (int i = 0; i < 4; i++) pull(d, v);
    do_rst();
    n_vec++; if (bus.in_valid_o !== 1'b0 || bus.level_o !== 5'd0) begin n_err++; $display("FAIL rstfly_a: got valid=%b level=%0d want 0/0", bus.in_valid_o, bus.level_o); end
    n_vec++; if (bus.pkt_avail_o !== 1'b0 || bus.app_in_ready_o !== 1'b1) begin n_err++; $display("FAIL rstfly_b: got avail=%b ready=%b want 0/1", bus.pkt_avail_o, bus.app_in_ready_o); end
  endtask

  task automatic test_empty();
    do_rst();
    bus.in_req_i = 1'b1; tick();
    n_vec++; if (bus.pkt_avail_o !== 1'b0 || bus.in_valid_o !== 1'b0) begin n_err++; $display("FAIL empty_req: got avail=%b valid=%b want 0/0", bus.pkt_avail_o, bus.in_valid_o); end
    bus.in_ready_i = 1'b1; tick();
    n_vec++; if (bus.in_valid_o !== 1'b0) begin n_err++; $display("FAIL empty_valid: got %b want 0", bus.in_valid_o); end
    bus.in_data_ack_i = 1'b1; tick();
    n_vec++; if (bus.level_o !== 5'd0 || bus.pkt_avail_o !== 1'b0) begin n_err++; $display("FAIL empty_ack: got level=%0d avail=%b want 0/0", bus.level_o, bus.pkt_avail_o); end
    wr_byte(8'h5A, 1'b1);
    bus.in_req_i = 1'b1; tick();
    n_vec++; if (bus.in_valid_o !== 1'b1 || bus.in_data_o !== 8'h5A || bus.level_o !== 5'd1) begin n_err++; $display("FAIL empty_then_wr: got v=%b d=%h level=%0d want 1/5a/1", bus.in_valid_o, bus.in_data_o, bus.level_o); end
    bus.in_abort_i = 1'b1; tick();
  endtask

  task automatic test_random();
    int r;
    bit ev;
    do_rst();
    for (int c = 0; c < 1500; c++) begin
      ev = m_valid();
      n_vec++; if (bus.in_valid_o !== ev) begin n_err++; $display("FAIL rnd_valid c%0d: got %b want %b", c, bus.in_valid_o, ev); end
      n_vec++; if (bus.level_o !== 5'(q.size())) begin n_err++; $display("FAIL rnd_level c%0d: got %0d want %0d", c, bus.level_o, q.size()); end
      n_vec++; if (bus.pkt_avail_o !== (q.size() != 0 || zlp)) begin n_err++; $display("FAIL rnd_avail c%0d: got %b want %b", c, bus.pkt_avail_o, (q.size() != 0 || zlp)); end
      n_vec++; if (bus.app_in_ready_o !== (q.size() < DEPTH)) begin n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.app_in_ready_o, (q.size() < DEPTH)); end
      if (ev) begin
        n_vec++; if (bus.in_data_o !== q[sp_off][7:0]) begin n_err++; $display("FAIL rnd_data c%0d: got %h want %h", c, bus.in_data_o, q[sp_off][7:0]); end
      end
      bus.app_in_valid_i = ($urandom_range(0, 9) < 6);
      bus.app_in_data_i  = 8'($urandom);
      bus.app_in_last_i  = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 99);
      if (r < 6) bus.in_req_i = 1'b1;
      else if (r < 13) bus.in_data_ack_i = 1'b1;
      else if (r < 17) bus.in_abort_i = 1'b1;
      else if (r < 19) begin bus.in_data_ack_i = 1'b1; bus.in_abort_i = 1'b1; end
      else bus.in_ready_i = ($urandom_range(0, 9) < 7);
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    test_reset();
    test_zlp();
    test_abort();
    test_full();
    test_ack_abort();
    test_reset_inflight();
    test_empty();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
